// File: rtl/fir_decim_mac.sv
// fir_decim_mac: decimating direct-form FIR, one multiply-accumulate per tap per clock.
// Optional build macro FIR_DECIM_ROUND_EN: round half toward +inf on the output shift instead of floor.
module fir_decim_mac #(
  parameter int ORDER  = 15,
  parameter int DECIM  = 4,
  parameter int SCALE  = 9,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [31:0]       in_data,
  input  logic                     coef_wr_en,
  input  logic [$clog2(ORDER)-1:0] coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [31:0]       out_data,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(ORDER);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = 32 + COEF_W;
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(ORDER - 1);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(DECIM - 1);
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_BIAS =
    (SCALE > 0) ? (ACC_W'(1) << ((SCALE > 0) ? (SCALE - 1) : 0)) : ACC_W'(0);
`endif

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_MAC    = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(0)) ? LAST_PTR : p - PTR_W'(1);
  endfunction

  state_t                   state_r, state_next_s;
  logic signed [31:0]       samples_r [ORDER];
  logic signed [COEF_W-1:0] coefs_r   [ORDER];
  logic [PTR_W-1:0]         wr_ptr_r, rd_ptr_r, tap_r;
  logic [PH_W-1:0]          phase_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     in_ready_r, out_valid_r, busy_r;
  logic signed [31:0]       out_data_r;

  logic                     accept_s, last_phase_s, last_tap_s, out_fire_s, coef_we_s;
  logic signed [PROD_W-1:0] coef_ext_s, samp_ext_s, prod_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic signed [31:0]       out_next_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Handshake decode and tap datapath; in_ready_r is only ever high in ACCEPT.
  always_comb begin
    accept_s     = in_valid && in_ready_r;
    last_phase_s = (phase_r == LAST_PHASE);
    last_tap_s   = (tap_r == LAST_PTR);
    out_fire_s   = out_valid_r && out_ready;
    coef_we_s    = coef_wr_en && (state_r == ST_ACCEPT) && (int'(coef_wr_addr) < ORDER);
    coef_ext_s   = PROD_W'(coefs_r[tap_r]);
    samp_ext_s   = PROD_W'(samples_r[rd_ptr_r]);
    prod_s       = coef_ext_s * samp_ext_s;
`ifdef FIR_DECIM_ROUND_EN
    acc_sum_s    = acc_r + RND_BIAS;
`else
    acc_sum_s    = acc_r;
`endif
    out_next_s   = 32'(acc_sum_s >>> SCALE);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && last_phase_s) state_next_s = ST_MAC;
        else                          state_next_s = ST_ACCEPT;
      end
      ST_MAC: begin
        if (last_tap_s) state_next_s = ST_OUTPUT;
        else            state_next_s = ST_MAC;
      end
      ST_OUTPUT: begin
        if (out_fire_s) state_next_s = ST_ACCEPT;
        else            state_next_s = ST_OUTPUT;
      end
      default: state_next_s = ST_ACCEPT;
    endcase
  end

  // State, handshake outputs and MAC datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_ACCEPT;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      tap_r       <= '0;
      phase_r     <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == ST_ACCEPT);
      busy_r     <= (state_next_s != ST_ACCEPT);
      if (accept_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (last_phase_s) begin
          // Newest sample lands at wr_ptr_r on this edge; the convolution walks backwards from it.
          phase_r  <= '0;
          acc_r    <= '0;
          rd_ptr_r <= wr_ptr_r;
          tap_r    <= '0;
        end else begin
          phase_r <= phase_r + PH_W'(1);
        end
      end
      if (state_r == ST_MAC) begin
        acc_r    <= acc_r + ACC_W'(prod_s);
        rd_ptr_r <= ptr_dec(rd_ptr_r);
        tap_r    <= last_tap_s ? PTR_W'(0) : tap_r + PTR_W'(1);
      end
      // First OUTPUT cycle registers the scaled result; it then holds until accepted.
      if (state_r == ST_OUTPUT) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= out_next_s;
        end else if (out_fire_s) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  // Delay line and coefficient storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ORDER; i++) begin
        samples_r[i] <= '0;
        coefs_r[i]   <= '0;
      end
    end else begin
      if (accept_s)  samples_r[wr_ptr_r] <= in_data;
      if (coef_we_s) coefs_r[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule
